vrf_lane_seq: RTL and testbench
===============================

// Module: vrf_lane_seq
// PURPOSE
//  Vector instruction sequencer/execute stage directly upstream of the vector register file (vrf).
//  - Accepts one vector instruction (op, vd, vs0, vs1, vs2) per valid/ready handshake.
//  - Walks the vector in passes of lanes_p elements, driving the vrf read ports.
//  - Computes per-lane results and drives the vrf write port, writing the results back to vd.
// PARAMETERS
//  els_p   32  number of vector registers in vrf
//  vlen_p  8   elements per vector; must be a multiple of lanes_p
//  vdw_p   32  bits per element
//  lanes_p 4   parallel lanes
//  (local) passes_lp = vlen_p/lanes_p; v_addr_width_lp = SAFE_CLOG2(els_p); local_addr_width_lp = SAFE_CLOG2(vlen_p)
// PORTS
//  clk_i          in   1                      clock
//  reset_i        in   1                      synchronous, active-high reset
//  v_i            in   1                      instruction valid
//  op_i           in   2                      0=VADD 1=VSUB 2=VMUL 3=VMAC
//  vd_i           in   v_addr_width_lp        destination register
//  vs0_i/vs1_i/vs2_i in v_addr_width_lp each  source registers (vs2 used by VMAC only)
//  ready_o        out  1                      can accept instruction
//  done_o         out  1                      1-cycle pulse with final write of instruction
//  r_reg0_addr_o/r_reg1_addr_o/r_reg2_addr_o  out [lanes_p][v_addr_width_lp]  vrf read register selects
//  r_addr_o       out  [lanes_p][local_addr_width_lp]  element index per lane
//  r0_data_i/r1_data_i/r2_data_i  in [lanes_p][vdw_p]  vrf read data, combinational from r_* addresses
//  w_reg_addr_o   out  v_addr_width_lp        vrf write register
//  w_addr_o       out  [lanes_p][local_addr_width_lp]  element index per lane
//  w_data_o       out  [lanes_p][vdw_p]       write data
//  w_en_o         out  lanes_p                per-lane write enable
// BEHAVIOUR
//  - States: IDLE, EXEC, DRAIN.
//    - Instruction is latched and pass counter p is cleared on v_i & ready_o.
//  - ready_o = (state==IDLE) & ~reset_i. v_i is ignored when ready_o=0.
//  - Transitions:
//    - IDLE -> EXEC on accept.
//    - EXEC advances p each cycle.
//    - EXEC -> DRAIN when p==passes_lp-1.
//    - DRAIN -> IDLE unconditionally.
//  - EXEC read stage:
//    - r_reg0/1/2_addr_o[l] = latched vs0/vs1/vs2 for all lanes.
//    - r_addr_o[l] = p*lanes_p + l.
//    - Operands are captured into the write-stage register at the clock edge.
//  - Write stage (one cycle after the read of a pass):
//    - w_reg_addr_o = vd.
//    - w_addr_o[l] = captured element index.
//    - w_en_o = {lanes_p{wb_valid}}.
//    - Writes of pass p-1 overlap reads of pass p.
//  - Arithmetic: unsigned, result truncated to vdw_p bits (modulo 2^vdw_p).
//    - VADD = a+b; VSUB = a-b; VMUL = low vdw_p bits of a*b; VMAC = low vdw_p bits of a*b+c.
//    - a, b, c = r0, r1, r2 data.
//  - Latency: accept at cycle 0, reads in cycles 1..passes_lp, writes in cycles 2..passes_lp+1.
//    - done_o is high in cycle passes_lp+1 with the last write.
//    - ready_o is high again in cycle passes_lp+2, so the next instruction is accepted then.
//  - Aliasing: vd equal to any source is legal; each element is read before it is written and passes are disjoint.
//  - When idle, r_* outputs hold their last values.
//  - w_en_o=0 whenever no write-stage data is valid; w_addr_o/w_data_o are don't-care then.
//  - Reset (any cycle, including mid-instruction), effective on the next cycle:
//    - state=IDLE, p=0, wb_valid=0, w_en_o=0, done_o=0.
//    - All address/data outputs = 0; no further writes from the aborted instruction.
// TESTING (vlen_p=8, lanes_p=4, vdw_p=32, passes_lp=2)
//  1. VADD: v1[i]=i, v2[i]=10*i; accept vd=3, vs0=1, vs1=2 at cycle 0.
//     -> cycle 2: w_en_o=4'hF, w_addr_o={3,2,1,0}.
//     -> cycle 3: w_addr_o={7,6,5,4}, done_o=1.
//     -> v3[i]=11*i; ready_o=1 at cycle 4.
//  2. Wrap: VADD of 32'hFFFF_FFFF + 1 -> 0.
//     VSUB 0-1 -> 32'hFFFF_FFFF.
//     VMUL 32'h1_0000*32'h1_0000 -> 0.
//  3. VMAC alias: vd=vs2=5, v5[i]=1, v1[i]=i, v2[i]=2 -> v5[i]=2*i+1.
//     Also: no element is read after it has been written.
//  4. Back-to-back: hold v_i=1 with two instructions.
//     -> second is accepted at cycle 4, exactly when ready_o rises.
//     -> v_i is ignored in cycles 1-3; writes of the two instructions are contiguous per timing.
//  5. Reset at cycle 2 mid-VADD -> cycle 3: w_en_o=0, done_o=0, ready_o=1.
//     -> the pass-1 elements of vd are unchanged.
//  6. Random op/regs for 1000 instructions vs a golden model of the 32-register file.
//     -> exactly one done_o per accepted instruction.

Source files
------------

// File: rtl/vrf_lane_seq.sv
// -----------------------------------------------------------------------------
// vrf_lane_seq
//
// Vector sequencer / execute stage that sits directly in front of the vector
// register file. It accepts one vector instruction per valid/ready handshake,
// then walks the vector in passes of lanes_p elements. In each pass it drives
// the vrf read ports, captures the operands, and one cycle later writes the
// per-lane results back to the destination register.
//
// Pipeline (passes_lp = vlen_p / lanes_p):
//   cycle 0                : instruction accepted
//   cycles 1..passes_lp    : read stage (EXEC), one pass per cycle
//   cycles 2..passes_lp+1  : write stage, done_o with the final write (DRAIN)
//   cycle passes_lp+2      : ready_o high again
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   v_i / ready_o                  instruction handshake
//   op_i                           0=VADD 1=VSUB 2=VMUL 3=VMAC (a*b+c)
//   vd_i, vs0_i, vs1_i, vs2_i      destination and source register numbers
//   done_o                         1-cycle pulse with the last write
//   r_reg{0,1,2}_addr_o, r_addr_o  vrf read selects (register, element/lane)
//   r{0,1,2}_data_i                vrf read data, combinational from r_*
//   w_reg_addr_o, w_addr_o         vrf write selects (register, element/lane)
//   w_data_o, w_en_o               vrf write data and per-lane enables
//
// vlen_p must be a multiple of lanes_p.
// -----------------------------------------------------------------------------
module vrf_lane_seq #(
  parameter int els_p   = 32,
  parameter int vlen_p  = 8,
  parameter int vdw_p   = 32,
  parameter int lanes_p = 4,
  localparam int passes_lp           = vlen_p / lanes_p,
  localparam int v_addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int local_addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1
) (
  input  logic                                               clk_i,
  input  logic                                               reset_i,

  input  logic                                               v_i,
  input  logic [1:0]                                         op_i,
  input  logic [v_addr_width_lp-1:0]                         vd_i,
  input  logic [v_addr_width_lp-1:0]                         vs0_i,
  input  logic [v_addr_width_lp-1:0]                         vs1_i,
  input  logic [v_addr_width_lp-1:0]                         vs2_i,
  output logic                                               ready_o,
  output logic                                               done_o,

  output logic [lanes_p-1:0][v_addr_width_lp-1:0]            r_reg0_addr_o,
  output logic [lanes_p-1:0][v_addr_width_lp-1:0]            r_reg1_addr_o,
  output logic [lanes_p-1:0][v_addr_width_lp-1:0]            r_reg2_addr_o,
  output logic [lanes_p-1:0][local_addr_width_lp-1:0]        r_addr_o,
  input  logic [lanes_p-1:0][vdw_p-1:0]                      r0_data_i,
  input  logic [lanes_p-1:0][vdw_p-1:0]                      r1_data_i,
  input  logic [lanes_p-1:0][vdw_p-1:0]                      r2_data_i,

  output logic [v_addr_width_lp-1:0]                         w_reg_addr_o,
  output logic [lanes_p-1:0][local_addr_width_lp-1:0]        w_addr_o,
  output logic [lanes_p-1:0][vdw_p-1:0]                      w_data_o,
  output logic [lanes_p-1:0]                                 w_en_o
);

  localparam int pass_width_lp = (passes_lp > 1) ? $clog2(passes_lp) : 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_MAC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                                      r_state;
  state_e                                      w_state_next;

  logic [pass_width_lp-1:0]                    r_pass;

  // Latched instruction
  logic [1:0]                                  r_op;
  logic [v_addr_width_lp-1:0]                  r_vd;
  logic [v_addr_width_lp-1:0]                  r_vs0;
  logic [v_addr_width_lp-1:0]                  r_vs1;
  logic [v_addr_width_lp-1:0]                  r_vs2;

  // Element index currently presented on the read port, per lane
  logic [lanes_p-1:0][local_addr_width_lp-1:0] r_rd_idx;

  // Write-stage register: operands and element index of the previous pass
  logic                                        r_wb_valid;
  logic [lanes_p-1:0][vdw_p-1:0]               r_wb_a;
  logic [lanes_p-1:0][vdw_p-1:0]               r_wb_b;
  logic [lanes_p-1:0][vdw_p-1:0]               r_wb_c;
  logic [lanes_p-1:0][local_addr_width_lp-1:0] r_wb_idx;

  logic                                        w_accept;
  logic                                        w_last_pass;
  logic                                        w_advance;

  assign w_accept    = v_i & ready_o;
  assign w_last_pass = (r_pass == pass_width_lp'(passes_lp - 1));
  assign w_advance   = (r_state == ST_EXEC) & ~w_last_pass;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_EXEC;
      ST_EXEC:  if (w_last_pass) w_state_next = ST_DRAIN;
      ST_DRAIN: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // DRAIN is the cycle holding the final pass in the write stage, so done_o
  // lines up with the last write. ready_o is masked by reset so nothing is
  // accepted in a reset cycle.
  always_comb begin
    ready_o = (r_state == ST_IDLE) & ~reset_i;
    done_o  = (r_state == ST_DRAIN);
    w_en_o  = {lanes_p{r_wb_valid}};
  end

  // ---------------------------------------------------------------------------
  // Instruction latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_op  <= '0;
      r_vd  <= '0;
      r_vs0 <= '0;
      r_vs1 <= '0;
      r_vs2 <= '0;
    end else if (w_accept) begin
      r_op  <= op_i;
      r_vd  <= vd_i;
      r_vs0 <= vs0_i;
      r_vs1 <= vs1_i;
      r_vs2 <= vs2_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Pass counter and read element indices
  // ---------------------------------------------------------------------------
  // The read indices are registered (rather than derived from r_pass) so that
  // they read zero after reset and hold their last value while idle. Each
  // pass steps every lane forward by lanes_p elements.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pass   <= '0;
      r_rd_idx <= '0;
    end else if (w_accept) begin
      r_pass <= '0;
      for (int l = 0; l < lanes_p; l++) begin
        r_rd_idx[l] <= local_addr_width_lp'(l);
      end
    end else if (w_advance) begin
      r_pass <= r_pass + 1'b1;
      for (int l = 0; l < lanes_p; l++) begin
        r_rd_idx[l] <= r_rd_idx[l] + local_addr_width_lp'(lanes_p);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-stage capture
  // ---------------------------------------------------------------------------
  // Operands of the pass being read this cycle are captured at the edge and
  // written back the following cycle, so writes of pass p-1 overlap reads of
  // pass p. Passes touch disjoint elements, which makes vd == vsN safe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wb_valid <= 1'b0;
      r_wb_a     <= '0;
      r_wb_b     <= '0;
      r_wb_c     <= '0;
      r_wb_idx   <= '0;
    end else begin
      r_wb_valid <= (r_state == ST_EXEC);
      if (r_state == ST_EXEC) begin
        r_wb_a   <= r0_data_i;
        r_wb_b   <= r1_data_i;
        r_wb_c   <= r2_data_i;
        r_wb_idx <= r_rd_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane read selects and arithmetic
  // ---------------------------------------------------------------------------
  assign w_reg_addr_o = r_vd;

  for (genvar gi = 0; gi < lanes_p; gi++) begin : g_lane
    logic [vdw_p-1:0] w_lane_prod;
    logic [vdw_p-1:0] w_lane_result;

    assign r_reg0_addr_o[gi] = r_vs0;
    assign r_reg1_addr_o[gi] = r_vs1;
    assign r_reg2_addr_o[gi] = r_vs2;
    assign r_addr_o[gi]      = r_rd_idx[gi];

    // All operations are unsigned and wrap modulo 2^vdw_p; only the low
    // vdw_p bits of the product are ever needed.
    always_comb begin
      w_lane_prod   = r_wb_a[gi] * r_wb_b[gi];
      w_lane_result = '0;
      case (r_op)
        OP_ADD:  w_lane_result = r_wb_a[gi] + r_wb_b[gi];
        OP_SUB:  w_lane_result = r_wb_a[gi] - r_wb_b[gi];
        OP_MUL:  w_lane_result = w_lane_prod;
        OP_MAC:  w_lane_result = w_lane_prod + r_wb_c[gi];
        default: w_lane_result = '0;
      endcase
    end

    assign w_addr_o[gi] = r_wb_idx[gi];
    assign w_data_o[gi] = w_lane_result;
  end

endmodule

// File: tb/tb_vrf_lane_seq.sv
// -----------------------------------------------------------------------------
// tb_vrf_lane_seq
//
// Directed bench for vrf_lane_seq (vlen 8, 4 lanes, 32-bit elements). The
// bench models the vector register file itself (combinational read, write on
// the clock edge) and keeps an independent golden copy that is updated per
// accepted instruction. A negedge monitor tracks the cycle index within each
// instruction to check done/write timing and read-before-write ordering.
// -----------------------------------------------------------------------------
module tb_vrf_lane_seq;

  localparam int ELS    = 32;
  localparam int VLEN   = 8;
  localparam int VDW    = 32;
  localparam int LANES  = 4;
  localparam int PASSES = VLEN / LANES;
  localparam int AW     = 5;
  localparam int IW     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            reset_i;
  logic                            v_i;
  logic [1:0]                      op_i;
  logic [AW-1:0]                   vd_i, vs0_i, vs1_i, vs2_i;
  logic                            ready_o, done_o;
  logic [LANES-1:0][AW-1:0]        r_reg0_addr_o, r_reg1_addr_o, r_reg2_addr_o;
  logic [LANES-1:0][IW-1:0]        r_addr_o, w_addr_o;
  logic [LANES-1:0][VDW-1:0]       r0_data_i, r1_data_i, r2_data_i, w_data_o;
  logic [AW-1:0]                   w_reg_addr_o;
  logic [LANES-1:0]                w_en_o;

  vrf_lane_seq #(
    .els_p   (ELS),
    .vlen_p  (VLEN),
    .vdw_p   (VDW),
    .lanes_p (LANES)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .v_i           (v_i),
    .op_i          (op_i),
    .vd_i          (vd_i),
    .vs0_i         (vs0_i),
    .vs1_i         (vs1_i),
    .vs2_i         (vs2_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .r_reg0_addr_o (r_reg0_addr_o),
    .r_reg1_addr_o (r_reg1_addr_o),
    .r_reg2_addr_o (r_reg2_addr_o),
    .r_addr_o      (r_addr_o),
    .r0_data_i     (r0_data_i),
    .r1_data_i     (r1_data_i),
    .r2_data_i     (r2_data_i),
    .w_reg_addr_o  (w_reg_addr_o),
    .w_addr_o      (w_addr_o),
    .w_data_o      (w_data_o),
    .w_en_o        (w_en_o)
  );

  // Register file model and golden copy
  logic [VDW-1:0] mem  [ELS][VLEN];
  logic [VDW-1:0] gold [ELS][VLEN];
  logic           sync_req = 1'b0;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      r0_data_i[l] = mem[r_reg0_addr_o[l]][r_addr_o[l]];
      r1_data_i[l] = mem[r_reg1_addr_o[l]][r_addr_o[l]];
      r2_data_i[l] = mem[r_reg2_addr_o[l]][r_addr_o[l]];
    end
  end

  always @(posedge clk) begin
    if (sync_req) begin
      for (int r = 0; r < ELS; r++)
        for (int i = 0; i < VLEN; i++)
          mem[r][i] <= gold[r][i];
    end else begin
      for (int l = 0; l < LANES; l++)
        if (w_en_o[l]) mem[w_reg_addr_o][w_addr_o[l]] <= w_data_o[l];
    end
  end

  // Monitor: phase = cycle index since accept (0 when not in an instruction)
  int                  phase      = 0;
  int                  done_total = 0;
  int                  acc_total  = 0;
  int                  rbw_err    = 0;
  int                  done_bad   = 0;
  int                  wen_bad    = 0;
  logic [ELS*VLEN-1:0] wr_seen    = '0;

  always @(negedge clk) begin
    if (phase >= 1 && phase <= PASSES) begin
      for (int l = 0; l < LANES; l++)
        if (wr_seen[{r_reg0_addr_o[l], r_addr_o[l]}] ||
            wr_seen[{r_reg1_addr_o[l], r_addr_o[l]}] ||
            wr_seen[{r_reg2_addr_o[l], r_addr_o[l]}])
          rbw_err <= rbw_err + 1;
    end
    if (done_o) begin
      done_total <= done_total + 1;
      if (phase != PASSES + 1) done_bad <= done_bad + 1;
    end
    if (w_en_o != '0 && !(phase >= 2 && phase <= PASSES + 1))
      wen_bad <= wen_bad + 1;
    for (int l = 0; l < LANES; l++)
      if (w_en_o[l]) wr_seen[{w_reg_addr_o, w_addr_o[l]}] <= 1'b1;
    if (reset_i) begin
      phase <= 0;
    end else if (v_i && ready_o) begin
      phase     <= 1;
      wr_seen   <= '0;
      acc_total <= acc_total + 1;
    end else if (phase != 0 && phase <= PASSES) begin
      phase <= phase + 1;
    end else begin
      phase <= 0;
    end
  end

  // Checking
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_mem();
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
  endtask

  task automatic gold_apply(input logic [1:0] op, input int vd, input int vs0,
                            input int vs1, input int vs2);
    logic [VDW-1:0] res [VLEN];
    logic [63:0]    a, b, c, t;
    for (int i = 0; i < VLEN; i++) begin
      a = 64'(gold[vs0][i]);
      b = 64'(gold[vs1][i]);
      c = 64'(gold[vs2][i]);
      case (op)
        2'd0:    t = a + b;
        2'd1:    t = a - b;
        2'd2:    t = a * b;
        default: t = a * b + c;
      endcase
      res[i] = t[31:0];
    end
    for (int i = 0; i < VLEN; i++) gold[vd][i] = res[i];
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 128'(guard), 128'd0);
  endtask

  task automatic issue(input logic [1:0] op, input int vd, input int vs0,
                       input int vs1, input int vs2);
    wait_idle();
    op_i  = op;
    vd_i  = AW'(vd);
    vs0_i = AW'(vs0);
    vs1_i = AW'(vs1);
    vs2_i = AW'(vs2);
    v_i   = 1'b1;
    tick();
    v_i   = 1'b0;
    gold_apply(op, vd, vs0, vs1, vs2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0]     rdy_hist, wen_hist, done_hist;
  logic [VDW-1:0] exp_v;
  int             acc0, done0;

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    op_i    = '0;
    vd_i    = '0;
    vs0_i   = '0;
    vs1_i   = '0;
    vs2_i   = '0;
    for (int r = 0; r < ELS; r++)
      for (int i = 0; i < VLEN; i++)
        gold[r][i] = 32'(r * 100 + i);
    for (int i = 0; i < VLEN; i++) begin
      gold[1][i] = 32'(i);
      gold[2][i] = 32'(10 * i);
    end
    tick(); tick(); tick();
    chk("rst_ready", 128'(ready_o), 128'd0);
    chk("rst_wen",   128'(w_en_o),  128'd0);
    chk("rst_done",  128'(done_o),  128'd0);
    reset_i = 1'b0;
    #1;
    chk("idle_ready",  128'(ready_o),      128'd1);
    chk("rst_raddr",   128'(r_addr_o),     128'd0);
    chk("rst_wregadr", 128'(w_reg_addr_o), 128'd0);
    sync_mem();

    // ---- 1. VADD v3 = v1 + v2, cycle-accurate ----
    chk("t1_c0_ready", 128'(ready_o), 128'd1);
    op_i = 2'd0; vd_i = 5'd3; vs0_i = 5'd1; vs1_i = 5'd2; vs2_i = 5'd0;
    v_i = 1'b1;
    tick();                                           // cycle 1
    v_i = 1'b0;
    chk("t1_c1_ready", 128'(ready_o),       128'd0);
    chk("t1_c1_raddr", 128'(r_addr_o),      128'h688);
    chk("t1_c1_rreg0", 128'(r_reg0_addr_o), 128'({4{5'd1}}));
    chk("t1_c1_rreg1", 128'(r_reg1_addr_o), 128'({4{5'd2}}));
    chk("t1_c1_wen",   128'(w_en_o),        128'd0);
    tick();                                           // cycle 2
    chk("t1_c2_wen",   128'(w_en_o),        128'hF);
    chk("t1_c2_waddr", 128'(w_addr_o),      128'h688);
    chk("t1_c2_wdata", w_data_o, {32'd33, 32'd22, 32'd11, 32'd0});
    chk("t1_c2_wreg",  128'(w_reg_addr_o),  128'd3);
    chk("t1_c2_done",  128'(done_o),        128'd0);
    chk("t1_c2_raddr", 128'(r_addr_o),      128'hFAC);
    tick();                                           // cycle 3
    chk("t1_c3_wen",   128'(w_en_o),        128'hF);
    chk("t1_c3_waddr", 128'(w_addr_o),      128'hFAC);
    chk("t1_c3_wdata", w_data_o, {32'd77, 32'd66, 32'd55, 32'd44});
    chk("t1_c3_done",  128'(done_o),        128'd1);
    chk("t1_c3_ready", 128'(ready_o),       128'd0);
    tick();                                           // cycle 4
    chk("t1_c4_ready", 128'(ready_o),       128'd1);
    chk("t1_c4_done",  128'(done_o),        128'd0);
    chk("t1_c4_wen",   128'(w_en_o),        128'd0);
    gold_apply(2'd0, 3, 1, 2, 0);
    for (int i = 0; i < VLEN; i++) chk("t1_v3", 128'(mem[3][i]), 128'(11 * i));

    // ---- 2. wrap-around ----
    for (int i = 0; i < VLEN; i++) begin
      gold[4][i] = 32'hFFFF_FFFF;
      gold[6][i] = 32'd1;
      gold[7][i] = 32'd0;
      gold[8][i] = 32'h0001_0000;
    end
    sync_mem();
    issue(2'd0, 9, 4, 6, 0);
    issue(2'd1, 10, 7, 6, 0);
    issue(2'd2, 11, 8, 8, 0);
    wait_idle();
    for (int i = 0; i < VLEN; i++) begin
      chk("t2_add_wrap", 128'(mem[9][i]),  128'd0);
      chk("t2_sub_wrap", 128'(mem[10][i]), 128'hFFFF_FFFF);
      chk("t2_mul_wrap", 128'(mem[11][i]), 128'd0);
    end

    // ---- 3. VMAC with vd == vs2 ----
    for (int i = 0; i < VLEN; i++) begin
      gold[5][i] = 32'd1;
      gold[2][i] = 32'd2;
    end
    sync_mem();
    issue(2'd3, 5, 1, 2, 5);
    wait_idle();
    for (int i = 0; i < VLEN; i++) chk("t3_mac_alias", 128'(mem[5][i]), 128'(2 * i + 1));
    chk("t3_read_after_write", 128'(rbw_err), 128'd0);

    // ---- 4. back-to-back with v_i held ----
    acc0 = acc_total;
    chk("t4_c0_ready", 128'(ready_o), 128'd1);
    op_i = 2'd0; vd_i = 5'd13; vs0_i = 5'd1; vs1_i = 5'd1; vs2_i = 5'd0;
    v_i  = 1'b1;
    rdy_hist = '0; wen_hist = '0; done_hist = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      rdy_hist[c-1]  = ready_o;
      wen_hist[c-1]  = |w_en_o;
      done_hist[c-1] = done_o;
      if (c == 1) begin
        op_i = 2'd1; vd_i = 5'd14; vs0_i = 5'd2; vs1_i = 5'd1; vs2_i = 5'd0;
      end
      if (c == 5) begin
        chk("t4_b_vs0", 128'(r_reg0_addr_o), 128'({4{5'd2}}));
        v_i = 1'b0;
      end
    end
    chk("t4_ready_hist", 128'(rdy_hist),  128'b1000_1000);
    chk("t4_wen_hist",   128'(wen_hist),  128'b0110_0110);
    chk("t4_done_hist",  128'(done_hist), 128'b0100_0100);
    chk("t4_accepts",    128'(acc_total - acc0), 128'd2);
    gold_apply(2'd0, 13, 1, 1, 0);
    gold_apply(2'd1, 14, 2, 1, 0);
    for (int i = 0; i < VLEN; i++) begin
      exp_v = 32'd2 - 32'(i);
      chk("t4_a_v13", 128'(mem[13][i]), 128'(2 * i));
      chk("t4_b_v14", 128'(mem[14][i]), 128'(exp_v));
    end

    // ---- 5. reset mid-instruction ----
    for (int i = 0; i < VLEN; i++) gold[15][i] = 32'hDEAD_0000 + 32'(i);
    sync_mem();
    op_i = 2'd0; vd_i = 5'd15; vs0_i = 5'd1; vs1_i = 5'd2; vs2_i = 5'd0;
    v_i  = 1'b1;
    tick();                                           // cycle 1
    v_i  = 1'b0;
    tick();                                           // cycle 2
    chk("t5_c2_wen",   128'(w_en_o),  128'hF);
    chk("t5_c2_ready", 128'(ready_o), 128'd0);
    reset_i = 1'b1;
    tick();                                           // cycle 3
    reset_i = 1'b0;
    #1;
    chk("t5_c3_wen",   128'(w_en_o),        128'd0);
    chk("t5_c3_done",  128'(done_o),        128'd0);
    chk("t5_c3_ready", 128'(ready_o),       128'd1);
    chk("t5_c3_wreg",  128'(w_reg_addr_o),  128'd0);
    chk("t5_c3_raddr", 128'(r_addr_o),      128'd0);
    chk("t5_c3_rreg0", 128'(r_reg0_addr_o), 128'd0);
    chk("t5_c3_wdata", w_data_o,            128'd0);
    tick(); tick(); tick();
    for (int i = 0; i < LANES; i++) gold[15][i] = 32'(i + 2);
    for (int i = 0; i < VLEN; i++) begin
      exp_v = (i < LANES) ? 32'(i + 2) : (32'hDEAD_0000 + 32'(i));
      chk("t5_v15", 128'(mem[15][i]), 128'(exp_v));
    end

    // ---- 6. random instructions vs golden register file ----
    for (int r = 0; r < ELS; r++)
      for (int i = 0; i < VLEN; i++)
        gold[r][i] = $urandom;
    sync_mem();
    acc0  = acc_total;
    done0 = done_total;
    for (int n = 0; n < 1000; n++) begin
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)));
    end
    wait_idle();
    tick();
    chk("t6_accepts", 128'(acc_total - acc0),   128'd1000);
    chk("t6_dones",   128'(done_total - done0), 128'd1000);
    for (int r = 0; r < ELS; r++)
      for (int i = 0; i < VLEN; i++)
        chk("t6_vrf", 128'(mem[r][i]), 128'(gold[r][i]));
    chk("t6_read_after_write", 128'(rbw_err),  128'd0);
    chk("t6_done_timing",      128'(done_bad), 128'd0);
    chk("t6_wen_timing",       128'(wen_bad),  128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
